// File: rtl/multi_clk_en_gen.sv
`default_nettype none
// ============================================================================
//  Module      : multi_clk_en_gen
//  Description : Multi-channel programmable clock-enable / PWM divider with
//                run-time reloadable divide and high counts, applied only at
//                period boundaries. Optional define MCEG_SYNC_EN adds a
//                global phase-align input (sync).
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_clk_en_gen #(
    parameter  int NUM_CH   = 3,
    parameter  int CNT_W    = 32,
    parameter  int DEF_DIV  = 10000,
    parameter  int DEF_HIGH = 5000,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MCEG_SYNC_EN
    input  logic              sync,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic [CNT_W-1:0]  wr_high,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out
);

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_DEF_DIV  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_DEF_HIGH = CNT_W'(DEF_HIGH);

    logic              w_sync;
    logic [31:0]       w_wr_ch_ext;
    logic              w_wr_fire;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_hit;

`ifdef MCEG_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    assign w_wr_ch_ext = 32'(wr_ch);

    // Out-of-range channel numbers are always accepted and simply dropped.
    always_comb begin
        wr_ready = 1'b1;
        w_hit    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_wr_ch_ext == 32'(k)) begin
                wr_ready = ~w_pending[k];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit[k] = w_wr_fire && (w_wr_ch_ext == 32'(k));
        end
    end

    assign w_wr_fire = wr_valid & wr_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div_act;
        logic [CNT_W-1:0] r_high_act;
        logic [CNT_W-1:0] r_div_sh;
        logic [CNT_W-1:0] r_high_sh;
        logic             r_pending;
        logic             r_tick;
        logic             r_div_out;

        logic             w_run;
        logic             w_wrap;
        logic             w_sync_ch;
        logic             w_boundary;
        logic             w_apply;
        logic [CNT_W-1:0] w_src_div;
        logic [CNT_W-1:0] w_src_high;
        logic [CNT_W-1:0] w_new_div;
        logic [CNT_W-1:0] w_new_high;
        logic [CNT_W-1:0] w_cnt_inc;

        assign w_run      = ch_en[gi] && (r_div_act != '0);
        assign w_wrap     = w_run && (r_cnt == r_div_act - c_CNT_ONE);
        assign w_sync_ch  = w_sync && ch_en[gi];
        assign w_boundary = w_sync_ch || w_wrap;

        // A stored update waits for a boundary or an idle channel; a write
        // landing exactly on a boundary bypasses the shadow and takes effect
        // immediately.
        assign w_apply    = r_pending ? (w_boundary || !w_run)
                                      : (w_hit[gi] && w_boundary);
        assign w_src_div  = r_pending ? r_div_sh  : wr_div;
        assign w_src_high = r_pending ? r_high_sh : wr_high;
        assign w_new_div  = w_apply ? w_src_div  : r_div_act;
        assign w_new_high = w_apply ? w_src_high : r_high_act;
        assign w_cnt_inc  = r_cnt + c_CNT_ONE;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt      <= '0;
                r_div_act  <= c_DEF_DIV;
                r_high_act <= c_DEF_HIGH;
                r_div_sh   <= '0;
                r_high_sh  <= '0;
                r_pending  <= 1'b0;
                r_tick     <= 1'b0;
                r_div_out  <= 1'b0;
            end else begin
                if (w_hit[gi]) begin
                    r_div_sh  <= wr_div;
                    r_high_sh <= wr_high;
                end

                if (w_apply) begin
                    r_div_act  <= w_new_div;
                    r_high_act <= w_new_high;
                    r_pending  <= 1'b0;
                end else if (w_hit[gi]) begin
                    r_pending  <= 1'b1;
                end

                if (w_sync_ch) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b0;
                    r_div_out <= (w_new_div != '0) && (w_new_high != '0);
                end else if (!w_run) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b0;
                    r_div_out <= 1'b0;
                end else if (w_wrap) begin
                    r_cnt     <= '0;
                    r_tick    <= 1'b1;
                    r_div_out <= (w_new_high != '0);
                end else begin
                    r_cnt     <= w_cnt_inc;
                    r_tick    <= 1'b0;
                    r_div_out <= (w_cnt_inc < r_high_act);
                end
            end
        end

        assign tick[gi]      = r_tick;
        assign div_out[gi]   = r_div_out;
        assign w_pending[gi] = r_pending;
    end

endmodule
`default_nettype wire
